hue_stage1_pipe: RTL and testbench

HUE_STAGE1_PIPE -- requirements
Module: hue_stage1_pipe

---
 rtl/hue_stage1_pipe_if.sv | 26 ++
 rtl/hue_stage1_pipe.sv | 185 ++++++++++++++++++
 tb/tb_hue_stage1_pipe.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hue_stage1_pipe_if.sv
// Sample/result bus for hue_stage1_pipe.
// The master side drives samples in and accepts results; the slave side is the pipe.
interface hue_stage1_pipe_if #(
  parameter int DW = 16
) ();
  logic [DW-1:0] i_data;
  logic [1:0]    i_function;
  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic          o_grey;
  logic          o_err;
  logic          o_valid;
  logic          o_ready;
  logic [31:0]   o_count;

  modport master (
    output i_data, i_function, i_valid, o_ready,
    input  i_ready, o_data, o_grey, o_err, o_valid, o_count
  );

  modport slave (
    input  i_data, i_function, i_valid, o_ready,
    output i_ready, o_data, o_grey, o_err, o_valid, o_count
  );
endinterface

// File: rtl/hue_stage1_pipe.sv
// hue_stage1_pipe: two-stage hue sector pipeline.
//   S1 registers the signed product i_data*SCALE and the sector select.
//   S2 adds the sector offset, applies a single wrap into 0..6*SCALE-1 and
//   registers the result together with grey/error flags.
// Optional feature macro: HUE_STAGE1_PIPE_STATS_EN builds a 32-bit counter of
// output handshakes on o_count; without it o_count is tied to zero.
module hue_stage1_pipe #(
  parameter int DW    = 16,
  parameter int SCALE = 60
) (
  input logic              i_clk,
  input logic              i_rst,
  hue_stage1_pipe_if.slave bus
);

  localparam int PW = 2 * DW;
  localparam int SW = 2 * DW + 1;

  localparam logic signed [PW-1:0] SCALE_P     = PW'(SCALE);
  localparam logic signed [SW-1:0] OFF_G_P     = SW'(2 * SCALE);
  localparam logic signed [SW-1:0] OFF_B_P     = SW'(4 * SCALE);
  localparam logic signed [SW-1:0] HUE_RANGE_P = SW'(6 * SCALE);
  localparam logic signed [SW-1:0] ZERO_P      = {SW{1'b0}};

  // Stage 1 state
  logic                 s1_valid_q, s1_valid_d;
  logic signed [PW-1:0] s1_prod_q,  s1_prod_d;
  logic [1:0]           s1_func_q,  s1_func_d;

  // Stage 2 state (drives the outputs directly)
  logic                 o_valid_q,  o_valid_d;
  logic [DW-1:0]        o_data_q,   o_data_d;
  logic                 o_grey_q,   o_grey_d;
  logic                 o_err_q,    o_err_d;

  // Combinational helpers
  logic                 s2_adv_s;
  logic                 i_ready_s;
  logic signed [PW-1:0] data_ext_s;
  logic signed [PW-1:0] prod_s;
  logic signed [SW-1:0] offset_s;
  logic signed [SW-1:0] sum_s;
  logic signed [SW-1:0] corr_s;
  logic                 err_s;

  // Flow control: S2 moves when empty or being consumed; S1 may load when it can hand off.
  always_comb begin
    s2_adv_s  = 1'b0;
    i_ready_s = 1'b0;
    s2_adv_s  = !o_valid_q || bus.o_ready;
    i_ready_s = !s1_valid_q || s2_adv_s;
  end

  // Signed product of the incoming difference and the sector scale.
  always_comb begin
    data_ext_s = {{DW{bus.i_data[DW-1]}}, bus.i_data};
    prod_s     = data_ext_s * SCALE_P;
  end

  // Stage 1 next state: load on acceptance, drain when handed off, otherwise hold.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_prod_d  = s1_prod_q;
    s1_func_d  = s1_func_q;
    if (i_ready_s) begin
      s1_valid_d = bus.i_valid;
      if (bus.i_valid) begin
        s1_prod_d = prod_s;
        s1_func_d = bus.i_function;
      end else begin
        s1_prod_d = s1_prod_q;
        s1_func_d = s1_func_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Sector offset, single wrap correction and range check on the S1 contents.
  always_comb begin
    offset_s = ZERO_P;
    case (s1_func_q)
      2'd2:    offset_s = OFF_G_P;
      2'd3:    offset_s = OFF_B_P;
      default: offset_s = ZERO_P;
    endcase
    sum_s = {s1_prod_q[PW-1], s1_prod_q} + offset_s;
    if (sum_s < ZERO_P) begin
      corr_s = sum_s + HUE_RANGE_P;
    end else if (sum_s >= HUE_RANGE_P) begin
      corr_s = sum_s - HUE_RANGE_P;
    end else begin
      corr_s = sum_s;
    end
    err_s = (corr_s < ZERO_P) || (corr_s >= HUE_RANGE_P);
  end

  // Stage 2 next state: capture S1 when advancing, hold the result while stalled.
  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_grey_d  = o_grey_q;
    o_err_d   = o_err_q;
    if (s2_adv_s) begin
      o_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        if (s1_func_q == 2'd0) begin
          o_data_d = {DW{1'b0}};
          o_grey_d = 1'b1;
          o_err_d  = 1'b0;
        end else begin
          o_data_d = corr_s[DW-1:0];
          o_grey_d = 1'b0;
          o_err_d  = err_s;
        end
      end else begin
        o_data_d = o_data_q;
      end
    end else begin
      o_valid_d = o_valid_q;
    end
  end

  // Stage 1 registers; reset discards any in-flight sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_prod_q  <= {PW{1'b0}};
      s1_func_q  <= 2'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_prod_q  <= s1_prod_d;
      s1_func_q  <= s1_func_d;
    end
  end

  // Stage 2 / output registers; reset clears outputs immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid_q <= 1'b0;
      o_data_q  <= {DW{1'b0}};
      o_grey_q  <= 1'b0;
      o_err_q   <= 1'b0;
    end else begin
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_grey_q  <= o_grey_d;
      o_err_q   <= o_err_d;
    end
  end

`ifdef HUE_STAGE1_PIPE_STATS_EN
  logic [31:0] o_count_q, o_count_d;

  // Output handshake counter, wraps naturally at 2^32.
  always_comb begin
    o_count_d = o_count_q;
    if (o_valid_q && bus.o_ready) begin
      o_count_d = o_count_q + 32'd1;
    end else begin
      o_count_d = o_count_q;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_count_q <= 32'd0;
    end else begin
      o_count_q <= o_count_d;
    end
  end

  assign bus.o_count = o_count_q;
`else
  assign bus.o_count = 32'd0;
`endif

  assign bus.i_ready = i_ready_s;
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_grey  = o_grey_q;
  assign bus.o_err   = o_err_q;

endmodule

// File: tb/tb_hue_stage1_pipe.sv
// Testbench for hue_stage1_pipe: directed vectors plus randomized traffic,
// checked through a queue-based scoreboard fed by an arithmetic hue model.
module tb_hue_stage1_pipe;

  localparam int DW    = 16;
  localparam int SCALE = 60;
  localparam int HR    = 6 * SCALE;

  typedef struct packed {
    logic [15:0] d;
    logic        g;
    logic        e;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  int   hs_count;
  exp_t exp_q[$];

  hue_stage1_pipe_if #(.DW(DW)) bus ();

  hue_stage1_pipe #(.DW(DW), .SCALE(SCALE)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Hue from the sector rules using plain integer arithmetic.
  function automatic exp_t model(input logic [1:0] f, input logic [15:0] din);
    exp_t r;
    int   v;
    int   s;
    v = int'($signed(din));
    if (f == 2'd0) begin
      r.d = 16'd0;
      r.g = 1'b1;
      r.e = 1'b0;
    end else begin
      s = v * SCALE + (int'(f) - 1) * 2 * SCALE;
      if (s < 0) s = s + HR;
      else if (s >= HR) s = s - HR;
      r.e = (s < 0) || (s >= HR);
      r.d = s[15:0];
      r.g = 1'b0;
    end
    return r;
  endfunction

  // Input monitor: every accepted sample pushes its expected result.
  always @(negedge clk) begin
    if (!rst && bus.i_valid && bus.i_ready) begin
      exp_q.push_back(model(bus.i_function, bus.i_data));
    end
  end

  // Output monitor: pops and compares on each output handshake; checks hold while stalled.
  logic        held_v;
  logic [17:0] held_val;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held_v   = 1'b0;
      hs_count = 0;
    end else begin
      if (held_v) begin
        chk("stall_hold", {13'd0, bus.o_valid, bus.o_data, bus.o_grey, bus.o_err},
            {13'd0, 1'b1, held_val});
      end
      if (bus.o_valid && bus.o_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("o_data", {16'd0, bus.o_data}, {16'd0, e.d});
          chk("o_grey", {31'd0, bus.o_grey}, {31'd0, e.g});
          chk("o_err",  {31'd0, bus.o_err},  {31'd0, e.e});
        end
      end
      held_v   = bus.o_valid && !bus.o_ready;
      held_val = {bus.o_data, bus.o_grey, bus.o_err};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single sample with o_ready high: check it appears exactly two cycles after presentation.
  task automatic dir_vec(input logic [1:0] f, input logic [15:0] d,
                         input logic [15:0] ed, input logic eg, input logic ee);
    bus.i_valid    = 1'b1;
    bus.i_function = f;
    bus.i_data     = d;
    bus.o_ready    = 1'b1;
    @(negedge clk);
    chk("dir_accept", {31'd0, bus.i_ready}, 32'd1);
    step();
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("dir_lat_early", {31'd0, bus.o_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("dir_valid",  {31'd0, bus.o_valid}, 32'd1);
    chk("dir_data",   {16'd0, bus.o_data},  {16'd0, ed});
    chk("dir_grey",   {31'd0, bus.o_grey},  {31'd0, eg});
    chk("dir_err",    {31'd0, bus.o_err},   {31'd0, ee});
    step();
    @(negedge clk);
    chk("dir_one_cycle", {31'd0, bus.o_valid}, 32'd0);
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic check_count();
    @(negedge clk);
    #1;
`ifdef HUE_STAGE1_PIPE_STATS_EN
    chk("o_count", bus.o_count, hs_count);
`else
    chk("o_count", bus.o_count, 32'd0);
`endif
  endtask

  initial begin
    int sent;
    int hs0;
    n_cmp          = 0;
    n_fail         = 0;
    hs_count       = 0;
    rst            = 1'b1;
    bus.i_valid    = 1'b0;
    bus.i_function = 2'd0;
    bus.i_data     = 16'd0;
    bus.o_ready    = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_o_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_o_data",  {16'd0, bus.o_data},  32'd0);
    chk("rst_o_grey",  {31'd0, bus.o_grey},  32'd0);
    chk("rst_o_err",   {31'd0, bus.o_err},   32'd0);
    chk("rst_i_ready", {31'd0, bus.i_ready}, 32'd1);
    chk("rst_o_count", bus.o_count,          32'd0);
    step();
    rst = 1'b0;
    step();

    // Directed sector/wrap/error vectors
    dir_vec(2'd1, 16'd5,      16'd300, 1'b0, 1'b0);
    dir_vec(2'd1, 16'hFFFB,   16'd60,  1'b0, 1'b0);
    dir_vec(2'd3, 16'd3,      16'd60,  1'b0, 1'b0);
    dir_vec(2'd2, 16'd0,      16'd120, 1'b0, 1'b0);
    dir_vec(2'd0, 16'hABCD,   16'd0,   1'b1, 1'b0);
    dir_vec(2'd1, 16'd20,     16'd840, 1'b0, 1'b1);
    dir_vec(2'd2, 16'hFFF6,   16'hFF88, 1'b0, 1'b1);
    dir_vec(2'd3, 16'hFFFC,   16'd0,   1'b0, 1'b0);
    dir_vec(2'd2, 16'd4,      16'd0,   1'b0, 1'b0);
    dir_vec(2'd3, 16'd1,      16'd300, 1'b0, 1'b0);

    // Back-to-back 5 samples, output stalled 4 cycles from the first result
    hs0  = hs_count;
    sent = 0;
    for (int cyc = 0; cyc < 40 && !(sent == 5 && exp_q.size() == 0); cyc++) begin
      bus.i_valid    = (sent < 5);
      bus.i_function = 2'd2;
      bus.i_data     = 16'(sent + 1);
      bus.o_ready    = !(cyc >= 2 && cyc <= 5);
      @(negedge clk);
      if (cyc == 2) begin
        chk("bp_first_out", {31'd0, bus.o_valid}, 32'd1);
        chk("bp_i_ready",   {31'd0, bus.i_ready}, 32'd0);
        chk("bp_accepted",  sent,                 32'd2);
      end
      if (bus.i_valid && bus.i_ready) sent++;
      step();
    end
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    drain();
    chk("bp_outputs", hs_count - hs0, 32'd5);
    check_count();

    // Reset mid-stream with two samples in flight
    step();
    bus.o_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.i_valid    = 1'b1;
      bus.i_function = 2'd1;
      bus.i_data     = 16'(k + 2);
      step();
    end
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("mid_o_valid_pre", {31'd0, bus.o_valid}, 32'd1);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("async_o_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("async_i_ready", {31'd0, bus.i_ready}, 32'd1);
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_stale", {31'd0, bus.o_valid}, 32'd0);
      step();
    end
    dir_vec(2'd2, 16'd1, 16'd180, 1'b0, 1'b0);

    // Randomized traffic with random backpressure
    for (int cyc = 0; cyc < 800; cyc++) begin
      bus.i_valid    = ($urandom_range(9, 0) < 7);
      bus.i_function = 2'($urandom_range(3, 0));
      if ($urandom_range(1, 0) == 1) bus.i_data = 16'($urandom_range(140, 0)) - 16'd70;
      else bus.i_data = 16'($urandom);
      bus.o_ready    = ($urandom_range(9, 0) < 7);
      step();
    end
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    drain();
    check_count();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
